// File: rtl/paquete_filtros.sv
// Shared definitions for the image filtering pipeline: FSM states,
// image-dimension defaults and a width helper.
package paquete_filtros;

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      LECTURA = 2'd1,
      DRENAJE = 2'd2,
      FIN     = 2'd3
   } estado_t;

   localparam int BITS_PIXEL_DEF     = 8;
   localparam int ANCHO_IMAGEN_DEF   = 640;
   localparam int ALTO_IMAGEN_DEF    = 480;
   localparam int BITS_DIRECCION_DEF = 19;
   localparam int TAM_VENTANA_DEF    = 5;

   // Bits needed to hold values 0..valor-1, never less than one.
   function automatic int bits_para(input int valor);
      int b = 1;
      while ((1 << b) < valor) b++;
      return b;
   endfunction

endpackage

// File: rtl/fifo_salida_2.sv
// Two-entry output FIFO that decouples the pixel memory from the downstream
// window generator; head entry is exposed combinationally on data_out.
module fifo_salida_2
   import paquete_filtros::*;
#(
   parameter int BITS_PIXEL = BITS_PIXEL_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [BITS_PIXEL-1:0] data_in,
   output logic [BITS_PIXEL-1:0] data_out,
   output logic [1:0]            count,
   output logic                  empty
);

   logic [BITS_PIXEL-1:0] r_mem [2];
   logic                  r_ptr_esc;
   logic                  r_ptr_lec;
   logic [1:0]            r_cuenta;
   logic                  w_push;
   logic                  w_pop;

   assign w_push   = push && (r_cuenta != 2'd2);
   assign w_pop    = pop && (r_cuenta != 2'd0);
   assign data_out = r_mem[r_ptr_lec];
   assign count    = r_cuenta;
   assign empty    = (r_cuenta == 2'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem[0]  <= '0;
         r_mem[1]  <= '0;
         r_ptr_esc <= 1'b0;
         r_ptr_lec <= 1'b0;
         r_cuenta  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_ptr_esc] <= data_in;
            r_ptr_esc        <= ~r_ptr_esc;
         end
         if (w_pop) begin
            r_ptr_lec <= ~r_ptr_lec;
         end
         case ({w_push, w_pop})
            2'b10:   r_cuenta <= r_cuenta + 2'd1;
            2'b01:   r_cuenta <= r_cuenta - 2'd1;
            default: r_cuenta <= r_cuenta;
         endcase
      end
   end

endmodule

// File: rtl/emisor_pixeles.sv
// Streams one frame in raster order from a 1-cycle-latency pixel memory to
// the 5x5 window generator, flagging pixels that complete a full window.
module emisor_pixeles
   import paquete_filtros::*;
#(
   parameter int BITS_PIXEL     = BITS_PIXEL_DEF,
   parameter int ANCHO_IMAGEN   = ANCHO_IMAGEN_DEF,
   parameter int ALTO_IMAGEN    = ALTO_IMAGEN_DEF,
   parameter int BITS_DIRECCION = BITS_DIRECCION_DEF,
   parameter int TAM_VENTANA    = TAM_VENTANA_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      iniciar,
   output logic                      mem_lectura,
   output logic [BITS_DIRECCION-1:0] mem_direccion,
   input  logic [BITS_PIXEL-1:0]     mem_dato,
   input  logic                      listo_sig,
   output logic [BITS_PIXEL-1:0]     pixel_salida,
   output logic                      pixel_valido,
   output logic                      ventana_valida,
   output logic                      ocupado,
   output logic                      fin
);

   localparam int TOTAL_PIXELES = ANCHO_IMAGEN * ALTO_IMAGEN;
   localparam int BITS_COL      = bits_para(ANCHO_IMAGEN);
   localparam int BITS_FILA     = bits_para(ALTO_IMAGEN);

   estado_t                   r_estado;
   logic [BITS_DIRECCION-1:0] r_direccion;
   logic [BITS_COL-1:0]       r_col_sal;
   logic [BITS_FILA-1:0]      r_fila_sal;
   logic                      r_en_vuelo;
   logic                      r_fin;
   logic                      r_ocupado;

   logic [1:0]                w_cuenta_fifo;
   logic                      w_fifo_vacia;
   logic                      w_transferencia;
   logic [2:0]                w_ocupacion;
   logic                      w_lectura;
   logic                      w_ultima_dir;

   fifo_salida_2 #(
      .BITS_PIXEL (BITS_PIXEL)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (r_en_vuelo),
      .pop      (w_transferencia),
      .data_in  (mem_dato),
      .data_out (pixel_salida),
      .count    (w_cuenta_fifo),
      .empty    (w_fifo_vacia)
   );

   assign pixel_valido    = ~w_fifo_vacia;
   assign w_transferencia = pixel_valido && listo_sig;

   // Slots already committed (stored plus in flight), minus the one leaving now.
   assign w_ocupacion  = {1'b0, w_cuenta_fifo} + {2'b00, r_en_vuelo} - {2'b00, w_transferencia};
   assign w_lectura    = (r_estado == LECTURA) && (w_ocupacion < 3'd2);
   assign w_ultima_dir = (r_direccion == BITS_DIRECCION'(TOTAL_PIXELES - 1));

   assign mem_lectura    = w_lectura;
   assign mem_direccion  = r_direccion;
   assign ventana_valida = pixel_valido
                           && (r_col_sal  >= BITS_COL'(TAM_VENTANA - 1))
                           && (r_fila_sal >= BITS_FILA'(TAM_VENTANA - 1));
   assign ocupado        = r_ocupado;
   assign fin            = r_fin;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_estado    <= REPOSO;
         r_direccion <= '0;
         r_col_sal   <= '0;
         r_fila_sal  <= '0;
         r_en_vuelo  <= 1'b0;
         r_fin       <= 1'b0;
         r_ocupado   <= 1'b0;
      end else begin
         r_en_vuelo <= w_lectura;
         r_fin      <= 1'b0;

         if (w_transferencia) begin
            if (r_col_sal == BITS_COL'(ANCHO_IMAGEN - 1)) begin
               r_col_sal <= '0;
               if (r_fila_sal == BITS_FILA'(ALTO_IMAGEN - 1)) begin
                  r_fila_sal <= '0;
               end else begin
                  r_fila_sal <= r_fila_sal + BITS_FILA'(1);
               end
            end else begin
               r_col_sal <= r_col_sal + BITS_COL'(1);
            end
         end

         case (r_estado)
            REPOSO: begin
               if (iniciar) begin
                  r_estado    <= LECTURA;
                  r_ocupado   <= 1'b1;
                  r_direccion <= '0;
                  r_col_sal   <= '0;
                  r_fila_sal  <= '0;
               end
            end
            LECTURA: begin
               // The address register holds the last address once it has been issued.
               if (w_lectura) begin
                  if (w_ultima_dir) begin
                     r_estado <= DRENAJE;
                  end else begin
                     r_direccion <= r_direccion + BITS_DIRECCION'(1);
                  end
               end
            end
            DRENAJE: begin
               if (w_fifo_vacia && !r_en_vuelo) begin
                  r_estado <= FIN;
                  r_fin    <= 1'b1;
               end
            end
            FIN: begin
               r_estado  <= REPOSO;
               r_ocupado <= 1'b0;
            end
            default: begin
               r_estado  <= REPOSO;
               r_ocupado <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_emisor_pixeles.sv
// Directed self-checking bench for emisor_pixeles on a 6x5 image whose
// memory returns data equal to the address.
module tb_emisor_pixeles;

   localparam int BP    = 8;
   localparam int AN    = 6;
   localparam int AL    = 5;
   localparam int BD    = 5;
   localparam int TV    = 5;
   localparam int TOTAL = AN * AL;

   logic          clk = 1'b0;
   logic          reset;
   logic          iniciar;
   logic          mem_lectura;
   logic [BD-1:0] mem_direccion;
   logic [BP-1:0] mem_dato = '0;
   logic          listo_sig;
   logic [BP-1:0] pixel_salida;
   logic          pixel_valido;
   logic          ventana_valida;
   logic          ocupado;
   logic          fin;

   int nAserciones = 0;
   int nFallos     = 0;

   emisor_pixeles #(
      .BITS_PIXEL     (BP),
      .ANCHO_IMAGEN   (AN),
      .ALTO_IMAGEN    (AL),
      .BITS_DIRECCION (BD),
      .TAM_VENTANA    (TV)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .iniciar        (iniciar),
      .mem_lectura    (mem_lectura),
      .mem_direccion  (mem_direccion),
      .mem_dato       (mem_dato),
      .listo_sig      (listo_sig),
      .pixel_salida   (pixel_salida),
      .pixel_valido   (pixel_valido),
      .ventana_valida (ventana_valida),
      .ocupado        (ocupado),
      .fin            (fin)
   );

   always #5 clk = ~clk;

   // Synchronous memory: data equals address, one cycle after the read.
   always @(posedge clk) begin
      if (mem_lectura) mem_dato <= BP'(mem_direccion);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAserciones++;
      assert (obs === exp) else begin
         nFallos++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // modo: 0 ready always, 1 five-cycle stall, 2 ready toggling, 3 extra iniciar.
   // abortarTras >= 0 returns right after that pixel is transferred.
   // seguido returns in the cycle after fin so the next frame starts back to back.
   task automatic applyStimulus(input int modo, input int abortarTras, input bit seguido);
      int esperado    = 0;
      int rdEsperado  = 0;
      int primerValido = -1;
      int ultimaTrans = -1;
      int cicloFin    = -1;
      int nFin        = 0;
      int nVentanas   = 0;
      int lecturas    = 0;
      int trans       = 0;
      bit prevStall   = 1'b0;
      bit terminado   = 1'b0;
      logic [BP-1:0] prevPixel = '0;
      logic          prevVentana = 1'b0;
      iniciar = 1'b1;
      for (int ciclo = 0; ciclo < 200 && !terminado; ciclo++) begin
         if (ciclo > 0) iniciar = (modo == 3 && ciclo == 5);
         case (modo)
            1:       listo_sig = !(ciclo >= 3 && ciclo <= 7);
            2:       listo_sig = (ciclo % 2 == 0);
            default: listo_sig = 1'b1;
         endcase
         @(negedge clk);
         if (ciclo == 1) begin
            checkOutput("lectura_ciclo1", mem_lectura, 1);
            checkOutput("ocupado_ciclo1", ocupado, 1);
         end
         if (pixel_valido && primerValido < 0) begin
            primerValido = ciclo;
            checkOutput("primer_valido", ciclo, 3);
         end
         if (prevStall) begin
            checkOutput("estable_valido", pixel_valido, 1);
            checkOutput("estable_pixel", pixel_salida, prevPixel);
            checkOutput("estable_ventana", ventana_valida, prevVentana);
         end
         if (mem_lectura) begin
            checkOutput("direccion", mem_direccion, rdEsperado);
            rdEsperado++;
            lecturas++;
         end
         if (pixel_valido && listo_sig) begin
            checkOutput("pixel", pixel_salida, esperado);
            checkOutput("ventana", ventana_valida,
                        (esperado % AN >= TV - 1) && (esperado / AN >= TV - 1));
            nVentanas += int'(ventana_valida);
            ultimaTrans = ciclo;
            trans++;
            esperado++;
            if (abortarTras >= 0 && esperado == abortarTras + 1) terminado = 1'b1;
         end
         checkOutput("credito", (lecturas - trans) <= 2, 1);
         if (fin) begin
            nFin++;
            if (cicloFin < 0) begin
               cicloFin = ciclo;
               checkOutput("fin_latencia", ciclo, ultimaTrans + 2);
               checkOutput("pixeles_entregados", esperado, TOTAL);
            end
            if (seguido) terminado = 1'b1;
         end
         if (cicloFin >= 0 && ciclo == cicloFin + 1) begin
            checkOutput("ocupado_tras_fin", ocupado, 0);
            checkOutput("fin_un_ciclo", fin, 0);
         end
         if (cicloFin >= 0 && ciclo == cicloFin + 3) terminado = 1'b1;
         prevStall   = pixel_valido && !listo_sig;
         prevPixel   = pixel_salida;
         prevVentana = ventana_valida;
         @(posedge clk);
         #1;
      end
      if (abortarTras < 0) begin
         checkOutput("fin_visto", cicloFin >= 0, 1);
         checkOutput("num_fin", nFin, 1);
         checkOutput("num_ventanas", nVentanas, 2);
         checkOutput("total_lecturas", lecturas, TOTAL);
      end
      iniciar = 1'b0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_mem_lectura"}, mem_lectura, 0);
      checkOutput({tag, "_mem_direccion"}, mem_direccion, 0);
      checkOutput({tag, "_pixel_valido"}, pixel_valido, 0);
      checkOutput({tag, "_pixel_salida"}, pixel_salida, 0);
      checkOutput({tag, "_ventana_valida"}, ventana_valida, 0);
      checkOutput({tag, "_ocupado"}, ocupado, 0);
      checkOutput({tag, "_fin"}, fin, 0);
   endtask

   initial begin
      reset     = 1'b1;
      iniciar   = 1'b0;
      listo_sig = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkResetOutputs("reset_inicial");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] frame with listo_sig always high");
      applyStimulus(0, -1, 1'b0);

      $display("[TB] frame with five-cycle stall");
      applyStimulus(1, -1, 1'b0);

      $display("[TB] frame with toggling listo_sig");
      applyStimulus(2, -1, 1'b0);

      $display("[TB] frame with second iniciar during LECTURA");
      applyStimulus(3, -1, 1'b0);

      $display("[TB] frame aborted by reset after pixel 12");
      applyStimulus(0, 12, 1'b0);
      reset = 1'b1;
      #2;
      checkResetOutputs("reset_aborto");
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("sin_fin_abortado", fin, 0);
         checkOutput("reposo_tras_aborto", ocupado, 0);
         @(posedge clk);
         #1;
      end
      applyStimulus(0, -1, 1'b0);

      $display("[TB] two back-to-back frames");
      applyStimulus(0, -1, 1'b1);
      applyStimulus(0, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAserciones, nFallos);
      $finish;
   end

endmodule
